udp_echo_responder: RTL and testbench

//  Parametrised UDP echo engine between the UDP stack RX and TX paths. Accepts a decoded RX header

---
 rtl/udp_echo_pkg.sv | 32 +++
 rtl/axis_skid_buffer.sv | 66 ++++++
 rtl/udp_echo_responder.sv | 179 +++++++++++++++++
 tb/tb_udp_echo_responder.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_echo_pkg.sv
// Shared types and byte-lane helpers for the UDP echo responder.
package udp_echo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR_OUT = 2'd1,
        FWD     = 2'd2,
        DRAIN   = 2'd3
    } echo_state_t;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  UDP_PROTO     = 8'h11;

    // Keep vectors are at most 8 lanes wide (64-bit bus); narrower buses zero-extend.
    function automatic logic [3:0] keep_popcount(input logic [7:0] keep);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, keep[i]};
        end
        return n;
    endfunction

    function automatic logic [7:0] keep_mask(input logic [3:0] n);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i] = (4'(i) < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer: registered s_trdy, one-cycle latency, full throughput.
module axis_skid_buffer #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0] s_tkeep,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_trdy,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_trdy
);

    logic [DATA_W-1:0] data_p0, data_p1;
    logic [KEEP_W-1:0] keep_p0, keep_p1;
    logic              last_p0, last_p1;
    logic              vld_p0, vld_p1;
    logic              in_fire, out_open;

    assign s_trdy   = ~vld_p0;
    assign in_fire  = s_tvalid & ~vld_p0;
    assign out_open = ~vld_p1 | m_trdy;

    // Stage 0 is the skid slot, stage 1 drives the master port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            data_p0 <= '0;
            keep_p0 <= '0;
            last_p0 <= 1'b0;
            data_p1 <= '0;
            keep_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (out_open) begin
            vld_p0 <= 1'b0;
            vld_p1 <= vld_p0 | in_fire;
            if (vld_p0) begin
                data_p1 <= data_p0;
                keep_p1 <= keep_p0;
                last_p1 <= last_p0;
            end else if (in_fire) begin
                data_p1 <= s_tdata;
                keep_p1 <= s_tkeep;
                last_p1 <= s_tlast;
            end
        end else if (in_fire) begin
            vld_p0  <= 1'b1;
            data_p0 <= s_tdata;
            keep_p0 <= s_tkeep;
            last_p0 <= s_tlast;
        end
    end

    assign m_tdata  = data_p1;
    assign m_tkeep  = keep_p1;
    assign m_tlast  = last_p1;
    assign m_tvalid = vld_p1;

endmodule

// File: rtl/udp_echo_responder.sv
// UDP echo engine: filters on destination port, swaps addressing and re-emits header + payload.
module udp_echo_responder
    import udp_echo_pkg::*;
#(
    parameter int          AXI_DATA_WIDTH = 8,
    parameter logic [15:0] LISTEN_PORT    = 16'd7,
    parameter int          ANY_PORT       = 0,
    parameter int          MAX_PAYLOAD    = 1472,
    parameter logic [47:0] SRC_MAC        = 48'hDEADBEEF000A,
    parameter logic [31:0] SRC_IP         = 32'h10000000,
    parameter int          CNT_W          = 32,
    localparam int         KEEP_W         = AXI_DATA_WIDTH / 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      s_udp_rx_hdr_tvalid,
    output logic                      s_udp_rx_hdr_trdy,
    input  logic [15:0]               s_udp_rx_src_port,
    input  logic [15:0]               s_udp_rx_dst_port,
    input  logic [31:0]               s_ip_rx_src_ip_addr,
    input  logic [47:0]               s_eth_rx_src_mac_addr,
    input  logic [AXI_DATA_WIDTH-1:0] s_rx_axis_tdata,
    input  logic [KEEP_W-1:0]         s_rx_axis_tkeep,
    input  logic                      s_rx_axis_tvalid,
    input  logic                      s_rx_axis_tlast,
    output logic                      s_rx_axis_trdy,
    output logic                      m_udp_tx_hdr_tvalid,
    input  logic                      m_udp_tx_hdr_trdy,
    output logic [15:0]               m_udp_tx_src_port,
    output logic [15:0]               m_udp_tx_dst_port,
    output logic [31:0]               m_ip_tx_src_ip_addr,
    output logic [31:0]               m_ip_tx_dst_ip_addr,
    output logic [47:0]               m_eth_tx_src_mac_addr,
    output logic [47:0]               m_eth_tx_dst_mac_addr,
    output logic [15:0]               m_eth_tx_type,
    output logic [AXI_DATA_WIDTH-1:0] m_tx_axis_tdata,
    output logic [KEEP_W-1:0]         m_tx_axis_tkeep,
    output logic                      m_tx_axis_tvalid,
    output logic                      m_tx_axis_tlast,
    input  logic                      m_tx_axis_trdy,
    output logic [CNT_W-1:0]          o_echo_cnt,
    output logic [CNT_W-1:0]          o_drop_cnt,
    output logic [CNT_W-1:0]          o_trunc_cnt
);

    localparam logic [16:0] MAX17 = 17'(MAX_PAYLOAD);
    localparam logic [15:0] MAX16 = 16'(MAX_PAYLOAD);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    echo_state_t       state, state_next;
    logic              hdr_rdy_q;
    logic              last_seen;
    logic [15:0]       byte_cnt;
    logic [15:0]       hdr_src_port, hdr_dst_port;
    logic [31:0]       hdr_dst_ip;
    logic [47:0]       hdr_dst_mac;
    logic [CNT_W-1:0]  echo_cnt, drop_cnt, trunc_cnt;

    logic              hdr_fire, rx_fire, fwd_fire, port_match;
    logic              skid_rdy, skid_empty;
    logic [3:0]        beat_bytes;
    logic [16:0]       sum17;
    logic [3:0]        rem4;
    logic              trunc_beat;
    logic [KEEP_W-1:0] skid_keep;

    assign port_match = (ANY_PORT != 0) || (s_udp_rx_dst_port == LISTEN_PORT);
    assign hdr_fire   = s_udp_rx_hdr_tvalid & hdr_rdy_q;
    assign rx_fire    = s_rx_axis_tvalid & s_rx_axis_trdy;
    assign fwd_fire   = rx_fire & (state == FWD);
    assign skid_empty = ~m_tx_axis_tvalid & skid_rdy;

    // Ready and valid come straight from flops, never from the downstream ready.
    assign s_udp_rx_hdr_trdy   = hdr_rdy_q;
    assign s_rx_axis_trdy      = (state == DRAIN) | ((state == FWD) & ~last_seen & skid_rdy);
    assign m_udp_tx_hdr_tvalid = (state == HDR_OUT);

    // A beat that fills or overruns the budget becomes the last one sent.
    always_comb begin
        beat_bytes = keep_popcount(8'(s_rx_axis_tkeep));
        sum17      = {1'b0, byte_cnt} + 17'(beat_bytes);
        trunc_beat = s_rx_axis_tlast ? (sum17 > MAX17) : (sum17 >= MAX17);
        rem4       = 4'(MAX16 - byte_cnt);
        skid_keep  = trunc_beat ? (s_rx_axis_tkeep & KEEP_W'(keep_mask(rem4))) : s_rx_axis_tkeep;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (hdr_fire) state_next = port_match ? HDR_OUT : DRAIN;
            end
            HDR_OUT: begin
                if (m_udp_tx_hdr_trdy) state_next = FWD;
            end
            FWD: begin
                if (fwd_fire && trunc_beat && !s_rx_axis_tlast) state_next = DRAIN;
                else if (last_seen && skid_empty)                state_next = IDLE;
            end
            DRAIN: begin
                if (rx_fire && s_rx_axis_tlast) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hdr_rdy_q    <= 1'b0;
            last_seen    <= 1'b0;
            byte_cnt     <= '0;
            hdr_src_port <= '0;
            hdr_dst_port <= '0;
            hdr_dst_ip   <= '0;
            hdr_dst_mac  <= '0;
            echo_cnt     <= '0;
            drop_cnt     <= '0;
            trunc_cnt    <= '0;
        end else begin
            hdr_rdy_q <= (state_next == IDLE);
            if (hdr_fire) begin
                hdr_dst_port <= s_udp_rx_src_port;
                hdr_src_port <= s_udp_rx_dst_port;
                hdr_dst_ip   <= s_ip_rx_src_ip_addr;
                hdr_dst_mac  <= s_eth_rx_src_mac_addr;
                byte_cnt     <= '0;
                last_seen    <= 1'b0;
                if (!port_match) drop_cnt <= sat_inc(drop_cnt);
            end
            if (fwd_fire) begin
                byte_cnt <= sum17[15:0];
                if (s_rx_axis_tlast) last_seen <= 1'b1;
                if (trunc_beat)           trunc_cnt <= sat_inc(trunc_cnt);
                else if (s_rx_axis_tlast) echo_cnt  <= sat_inc(echo_cnt);
            end
        end
    end

    axis_skid_buffer #(
        .DATA_W (AXI_DATA_WIDTH),
        .KEEP_W (KEEP_W)
    ) u_skid (
        .clk      (i_clk),
        .rst_n    (i_reset_n),
        .s_tdata  (s_rx_axis_tdata),
        .s_tkeep  (skid_keep),
        .s_tvalid (fwd_fire),
        .s_tlast  (s_rx_axis_tlast | trunc_beat),
        .s_trdy   (skid_rdy),
        .m_tdata  (m_tx_axis_tdata),
        .m_tkeep  (m_tx_axis_tkeep),
        .m_tvalid (m_tx_axis_tvalid),
        .m_tlast  (m_tx_axis_tlast),
        .m_trdy   (m_tx_axis_trdy)
    );

    assign m_udp_tx_src_port     = hdr_src_port;
    assign m_udp_tx_dst_port     = hdr_dst_port;
    assign m_ip_tx_src_ip_addr   = SRC_IP;
    assign m_ip_tx_dst_ip_addr   = hdr_dst_ip;
    assign m_eth_tx_src_mac_addr = SRC_MAC;
    assign m_eth_tx_dst_mac_addr = hdr_dst_mac;
    assign m_eth_tx_type         = ETH_TYPE_IPV4;
    assign o_echo_cnt            = echo_cnt;
    assign o_drop_cnt            = drop_cnt;
    assign o_trunc_cnt           = trunc_cnt;

endmodule

// File: tb/tb_udp_echo_responder.sv
// Directed bench for udp_echo_responder on a 32-bit payload bus.
`timescale 1ns/1ps
module tb_udp_echo_responder;

    localparam int W  = 32;
    localparam int KW = W / 8;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          s_udp_rx_hdr_tvalid, s_udp_rx_hdr_trdy;
    logic [15:0]   s_udp_rx_src_port, s_udp_rx_dst_port;
    logic [31:0]   s_ip_rx_src_ip_addr;
    logic [47:0]   s_eth_rx_src_mac_addr;
    logic [W-1:0]  s_rx_axis_tdata;
    logic [KW-1:0] s_rx_axis_tkeep;
    logic          s_rx_axis_tvalid, s_rx_axis_tlast, s_rx_axis_trdy;
    logic          m_udp_tx_hdr_tvalid, m_udp_tx_hdr_trdy;
    logic [15:0]   m_udp_tx_src_port, m_udp_tx_dst_port, m_eth_tx_type;
    logic [31:0]   m_ip_tx_src_ip_addr, m_ip_tx_dst_ip_addr;
    logic [47:0]   m_eth_tx_src_mac_addr, m_eth_tx_dst_mac_addr;
    logic [W-1:0]  m_tx_axis_tdata;
    logic [KW-1:0] m_tx_axis_tkeep;
    logic          m_tx_axis_tvalid, m_tx_axis_tlast, m_tx_axis_trdy;
    logic [31:0]   o_echo_cnt, o_drop_cnt, o_trunc_cnt;

    always #5 i_clk = ~i_clk;

    udp_echo_responder #(
        .AXI_DATA_WIDTH (W),
        .LISTEN_PORT    (16'd7),
        .ANY_PORT       (0),
        .MAX_PAYLOAD    (1472),
        .SRC_MAC        (48'hDEADBEEF000A),
        .SRC_IP         (32'h10000000),
        .CNT_W          (32)
    ) dut (
        .i_clk                 (i_clk),
        .i_reset_n             (i_reset_n),
        .s_udp_rx_hdr_tvalid   (s_udp_rx_hdr_tvalid),
        .s_udp_rx_hdr_trdy     (s_udp_rx_hdr_trdy),
        .s_udp_rx_src_port     (s_udp_rx_src_port),
        .s_udp_rx_dst_port     (s_udp_rx_dst_port),
        .s_ip_rx_src_ip_addr   (s_ip_rx_src_ip_addr),
        .s_eth_rx_src_mac_addr (s_eth_rx_src_mac_addr),
        .s_rx_axis_tdata       (s_rx_axis_tdata),
        .s_rx_axis_tkeep       (s_rx_axis_tkeep),
        .s_rx_axis_tvalid      (s_rx_axis_tvalid),
        .s_rx_axis_tlast       (s_rx_axis_tlast),
        .s_rx_axis_trdy        (s_rx_axis_trdy),
        .m_udp_tx_hdr_tvalid   (m_udp_tx_hdr_tvalid),
        .m_udp_tx_hdr_trdy     (m_udp_tx_hdr_trdy),
        .m_udp_tx_src_port     (m_udp_tx_src_port),
        .m_udp_tx_dst_port     (m_udp_tx_dst_port),
        .m_ip_tx_src_ip_addr   (m_ip_tx_src_ip_addr),
        .m_ip_tx_dst_ip_addr   (m_ip_tx_dst_ip_addr),
        .m_eth_tx_src_mac_addr (m_eth_tx_src_mac_addr),
        .m_eth_tx_dst_mac_addr (m_eth_tx_dst_mac_addr),
        .m_eth_tx_type         (m_eth_tx_type),
        .m_tx_axis_tdata       (m_tx_axis_tdata),
        .m_tx_axis_tkeep       (m_tx_axis_tkeep),
        .m_tx_axis_tvalid      (m_tx_axis_tvalid),
        .m_tx_axis_tlast       (m_tx_axis_tlast),
        .m_tx_axis_trdy        (m_tx_axis_trdy),
        .o_echo_cnt            (o_echo_cnt),
        .o_drop_cnt            (o_drop_cnt),
        .o_trunc_cnt           (o_trunc_cnt)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] pat(input logic [7:0] seed, input int idx);
        return seed + 8'(idx * 3);
    endfunction

    // Output-side monitors, sampled on the falling edge.
    logic [7:0]  out_q[$];
    int          out_beats, out_lasts, hdr_seen;
    logic [3:0]  last_keep;
    logic [15:0] cap_src, cap_dst, cap_type;
    logic [31:0] cap_sip, cap_dip;
    logic [47:0] cap_smac, cap_dmac;

    always @(negedge i_clk) begin
        if (i_reset_n && m_tx_axis_tvalid && m_tx_axis_trdy) begin
            for (int k = 0; k < KW; k++)
                if (m_tx_axis_tkeep[k]) out_q.push_back(m_tx_axis_tdata[8*k +: 8]);
            out_beats++;
            if (m_tx_axis_tlast) begin
                out_lasts++;
                last_keep = m_tx_axis_tkeep;
            end
        end
        if (i_reset_n && m_udp_tx_hdr_tvalid && m_udp_tx_hdr_trdy) begin
            hdr_seen++;
            cap_src  = m_udp_tx_src_port;
            cap_dst  = m_udp_tx_dst_port;
            cap_sip  = m_ip_tx_src_ip_addr;
            cap_dip  = m_ip_tx_dst_ip_addr;
            cap_smac = m_eth_tx_src_mac_addr;
            cap_dmac = m_eth_tx_dst_mac_addr;
            cap_type = m_eth_tx_type;
        end
    end

    bit rand_trdy = 1'b0;
    always @(posedge i_clk) begin
        if (rand_trdy) begin
            #1;
            m_tx_axis_trdy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, finish required");
        $fatal(1);
    end

    task automatic clear_mon();
        out_q.delete();
        out_beats = 0;
        out_lasts = 0;
        hdr_seen  = 0;
        last_keep = '0;
    endtask

    task automatic wait_rdy(input bit sel, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge i_clk);
            if ((sel ? s_rx_axis_trdy : s_udp_rx_hdr_trdy) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge i_clk);
        #1;
        if (!ok) begin
            n_chk++;
            $display("FAIL %s_ready: timeout after 3000 cycles, ready required", sel ? "payload" : "header");
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge i_clk);
            if (s_udp_rx_hdr_trdy === 1'b1 && m_tx_axis_tvalid === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        @(posedge i_clk);
        #1;
        if (!done) begin
            n_chk++;
            $display("FAIL idle_wait: engine still busy after 500 cycles, idle required");
        end
    endtask

    task automatic drive_hdr(input logic [15:0] dst, input logic [15:0] src,
                             input logic [31:0] ip, input logic [47:0] mac, output bit ok);
        s_udp_rx_dst_port     = dst;
        s_udp_rx_src_port     = src;
        s_ip_rx_src_ip_addr   = ip;
        s_eth_rx_src_mac_addr = mac;
        s_udp_rx_hdr_tvalid   = 1'b1;
        wait_rdy(1'b0, ok);
        s_udp_rx_hdr_tvalid   = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] dst, input logic [15:0] src, input logic [31:0] ip,
                            input logic [47:0] mac, input int len, input logic [7:0] seed);
        bit ok;
        drive_hdr(dst, src, ip, mac, ok);
        for (int b = 0; b < len && ok; b += KW) begin
            s_rx_axis_tdata = '0;
            s_rx_axis_tkeep = '0;
            for (int k = 0; k < KW; k++) begin
                if (b + k < len) begin
                    s_rx_axis_tdata[8*k +: 8] = pat(seed, b + k);
                    s_rx_axis_tkeep[k]        = 1'b1;
                end
            end
            s_rx_axis_tlast  = (b + KW >= len);
            s_rx_axis_tvalid = 1'b1;
            wait_rdy(1'b1, ok);
        end
        s_rx_axis_tvalid = 1'b0;
        s_rx_axis_tlast  = 1'b0;
    endtask

    task automatic check_bytes(input string tag, input int exp_len, input logic [7:0] seed);
        int bad;
        bad = 0;
        for (int j = 0; j < out_q.size() && j < exp_len; j++)
            if (out_q[j] !== pat(seed, j)) bad++;
        check({tag, "_len"}, 64'(out_q.size()), 64'(exp_len));
        check({tag, "_bad_bytes"}, 64'(bad), 64'd0);
    endtask

    typedef struct {
        logic [15:0] dst;
        logic [15:0] src;
        logic [31:0] ip;
        logic [47:0] mac;
        int          len;
        bit          rnd;
        bit          hdr;
        int          out_len;
        int          out_beats;
        logic [3:0]  last_keep;
        int          echo;
        int          drop;
        int          trunc;
    } vec_t;

    vec_t tbl[5];

    initial begin
        bit ok;
        bit seen;

        // Counter columns are cumulative since reset.
        tbl[0] = '{16'd7,  16'd5000, 32'h0A000002, 48'h001122334455,   64, 1'b0, 1'b1,   64,  16, 4'hF, 1, 0, 0};
        tbl[1] = '{16'd80, 16'd1234, 32'h0A000003, 48'h0A0B0C0D0E0F,   20, 1'b0, 1'b0,    0,   0, 4'h0, 1, 1, 0};
        tbl[2] = '{16'd7,  16'd6000, 32'h0A000004, 48'h0000AABBCCDD, 1473, 1'b0, 1'b1, 1472, 368, 4'hF, 1, 1, 1};
        tbl[3] = '{16'd7,  16'd7000, 32'h0A000005, 48'h112233445566,    7, 1'b1, 1'b1,    7,   2, 4'h7, 2, 1, 1};
        tbl[4] = '{16'd7,  16'd8000, 32'h0A000006, 48'h223344556677, 1472, 1'b0, 1'b1, 1472, 368, 4'hF, 3, 1, 1};

        i_reset_n             = 1'b0;
        s_udp_rx_hdr_tvalid   = 1'b0;
        s_udp_rx_src_port     = '0;
        s_udp_rx_dst_port     = '0;
        s_ip_rx_src_ip_addr   = '0;
        s_eth_rx_src_mac_addr = '0;
        s_rx_axis_tdata       = '0;
        s_rx_axis_tkeep       = '0;
        s_rx_axis_tvalid      = 1'b0;
        s_rx_axis_tlast       = 1'b0;
        m_udp_tx_hdr_trdy     = 1'b1;
        m_tx_axis_trdy        = 1'b1;
        clear_mon();

        repeat (3) @(posedge i_clk);
        #1;
        check("rst_hdr_trdy",  s_udp_rx_hdr_trdy,   1'b0);
        check("rst_rx_trdy",   s_rx_axis_trdy,      1'b0);
        check("rst_hdr_valid", m_udp_tx_hdr_tvalid, 1'b0);
        check("rst_tx_valid",  m_tx_axis_tvalid,    1'b0);
        check("rst_tx_last",   m_tx_axis_tlast,     1'b0);
        check("rst_dst_port",  m_udp_tx_dst_port,   16'd0);
        check("rst_echo_cnt",  o_echo_cnt,          32'd0);
        check("rst_drop_cnt",  o_drop_cnt,          32'd0);
        check("rst_trunc_cnt", o_trunc_cnt,         32'd0);
        i_reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            clear_mon();
            rand_trdy = tbl[i].rnd;
            send_pkt(tbl[i].dst, tbl[i].src, tbl[i].ip, tbl[i].mac, tbl[i].len, 8'(i * 16 + 1));
            wait_idle();
            rand_trdy = 1'b0;
            @(posedge i_clk);
            #2;
            m_tx_axis_trdy = 1'b1;
            check($sformatf("v%0d_hdr_count", i), 64'(hdr_seen), 64'(tbl[i].hdr));
            check_bytes($sformatf("v%0d_payload", i), tbl[i].out_len, 8'(i * 16 + 1));
            check($sformatf("v%0d_beats", i), 64'(out_beats), 64'(tbl[i].out_beats));
            check($sformatf("v%0d_tlast_count", i), 64'(out_lasts), 64'(tbl[i].hdr));
            check($sformatf("v%0d_last_keep", i), last_keep, tbl[i].last_keep);
            check($sformatf("v%0d_echo_cnt", i), o_echo_cnt, 64'(tbl[i].echo));
            check($sformatf("v%0d_drop_cnt", i), o_drop_cnt, 64'(tbl[i].drop));
            check($sformatf("v%0d_trunc_cnt", i), o_trunc_cnt, 64'(tbl[i].trunc));
            if (tbl[i].hdr) begin
                check($sformatf("v%0d_tx_dst_port", i), cap_dst, tbl[i].src);
                check($sformatf("v%0d_tx_src_port", i), cap_src, tbl[i].dst);
                check($sformatf("v%0d_tx_dst_ip", i), cap_dip, tbl[i].ip);
                check($sformatf("v%0d_tx_dst_mac", i), cap_dmac, tbl[i].mac);
                check($sformatf("v%0d_tx_src_mac", i), cap_smac, 48'hDEADBEEF000A);
                check($sformatf("v%0d_tx_src_ip", i), cap_sip, 32'h10000000);
                check($sformatf("v%0d_eth_type", i), cap_type, 16'h0800);
            end
        end

        // Header stall: fields must hold and no payload may leave.
        clear_mon();
        m_udp_tx_hdr_trdy = 1'b0;
        fork
            send_pkt(16'd7, 16'd4242, 32'h0A000009, 48'h665544332211, 8, 8'h55);
            begin
                seen = 1'b0;
                for (int c = 0; c < 50 && !seen; c++) begin
                    @(negedge i_clk);
                    seen = m_udp_tx_hdr_tvalid;
                end
                check("stall_hdr_appeared", seen, 1'b1);
                for (int c = 0; c < 10; c++) begin
                    @(negedge i_clk);
                    check($sformatf("stall%0d_hdr_valid", c), m_udp_tx_hdr_tvalid, 1'b1);
                    check($sformatf("stall%0d_dst_port", c), m_udp_tx_dst_port, 16'd4242);
                    check($sformatf("stall%0d_dst_mac", c), m_eth_tx_dst_mac_addr, 48'h665544332211);
                    check($sformatf("stall%0d_tx_valid", c), m_tx_axis_tvalid, 1'b0);
                end
                @(posedge i_clk);
                #1;
                m_udp_tx_hdr_trdy = 1'b1;
            end
        join
        wait_idle();
        check_bytes("stall_payload", 8, 8'h55);
        check("stall_echo_cnt", o_echo_cnt, 32'd4);

        // Reset in the middle of forwarding, then a clean packet.
        clear_mon();
        drive_hdr(16'd7, 16'd9000, 32'h0A00000A, 48'h0102030405AB, ok);
        s_rx_axis_tdata  = 32'hCAFEF00D;
        s_rx_axis_tkeep  = 4'hF;
        s_rx_axis_tlast  = 1'b0;
        s_rx_axis_tvalid = 1'b1;
        repeat (6) @(negedge i_clk);
        check("midfwd_tx_valid", m_tx_axis_tvalid, 1'b1);
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b0;
        #1;
        check("arst_tx_valid",  m_tx_axis_tvalid,    1'b0);
        check("arst_tx_last",   m_tx_axis_tlast,     1'b0);
        check("arst_hdr_valid", m_udp_tx_hdr_tvalid, 1'b0);
        check("arst_rx_trdy",   s_rx_axis_trdy,      1'b0);
        check("arst_hdr_trdy",  s_udp_rx_hdr_trdy,   1'b0);
        check("arst_echo_cnt",  o_echo_cnt,          32'd0);
        check("arst_dst_port",  m_udp_tx_dst_port,   16'd0);
        s_rx_axis_tvalid = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        clear_mon();
        send_pkt(16'd7, 16'd9001, 32'h0A00000B, 48'h0A1B2C3D4E5F, 12, 8'h77);
        wait_idle();
        check_bytes("post_rst_payload", 12, 8'h77);
        check("post_rst_dst_port", cap_dst, 16'd9001);
        check("post_rst_echo_cnt", o_echo_cnt, 32'd1);
        check("post_rst_drop_cnt", o_drop_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
